// File: rtl/sum4_splitter_if.sv
// Handshake bundle for sum4_splitter: total input channel and share output channel.
interface sum4_splitter_if #(
  parameter int W_IN  = 6,
  parameter int W_OUT = 4,
  parameter int N_OUT = 4
);
  localparam int W_IDX = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [W_IN-1:0]   total_in;
  logic              out_valid;
  logic              out_ready;
  logic [W_OUT-1:0]  share_out;
  logic [W_IDX-1:0]  share_idx;
  logic              out_last;
  logic              err;

  modport master (
    output in_valid, total_in, out_ready,
    input  in_ready, out_valid, share_out, share_idx, out_last, err
  );

  modport slave (
    input  in_valid, total_in, out_ready,
    output in_ready, out_valid, share_out, share_idx, out_last, err
  );
endinterface

// File: rtl/sum4_splitter.sv
// Splits a total into N_OUT shares (greedy, or even split with SUM4_SPLIT_EVEN_EN); first share 1 cycle after accept.
// Output beats hold while out_ready is low; in_ready stays low until the last beat completes.
module sum4_splitter #(
  parameter int W_IN  = 6,
  parameter int W_OUT = 4,
  parameter int N_OUT = 4
) (
  input logic           clk,
  input logic           reset,
  sum4_splitter_if.slave s
);
  localparam int W_IDX = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [W_OUT-1:0] SHARE_MAX_N = '1;
  localparam logic [W_IN-1:0]  SHARE_MAX   = W_IN'((1 << W_OUT) - 1);
  localparam logic [W_IN-1:0]  TMAX        = W_IN'(N_OUT * ((1 << W_OUT) - 1));
  localparam logic [W_IDX-1:0] IDX_LAST    = W_IDX'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W_IN-1:0]  r_rem;
  logic [W_IDX-1:0] r_idx;
  logic [W_OUT-1:0] w_share;
  logic             w_accept;
  logic             w_in_range;
  logic             w_beat;
  logic             w_last;

  assign w_accept   = (r_state == IDLE) && s.in_valid;
  assign w_in_range = (s.total_in <= TMAX);
  assign w_beat     = (r_state == EMIT) && s.out_ready;
  assign w_last     = (r_idx == IDX_LAST);

`ifdef SUM4_SPLIT_EVEN_EN
  // Base share plus one extra unit for the first (T mod N_OUT) beats.
  logic [W_OUT-1:0] r_base;
  logic [W_IDX-1:0] r_extra;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base  <= '0;
      r_extra <= '0;
    end else if (w_accept && w_in_range) begin
      r_base  <= W_OUT'(s.total_in / N_OUT);
      r_extra <= W_IDX'(s.total_in % N_OUT);
    end
  end

  assign w_share = r_base + W_OUT'(r_idx < r_extra);
`else
  assign w_share = (r_rem > SHARE_MAX) ? SHARE_MAX_N : r_rem[W_OUT-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (s.in_valid) w_next = w_in_range ? EMIT : ERR;
      EMIT:    if (s.out_ready && w_last) w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
      r_idx <= '0;
    end else if (w_accept && w_in_range) begin
      r_rem <= s.total_in;
      r_idx <= '0;
    end else if (w_beat) begin
      r_rem <= r_rem - {{(W_IN-W_OUT){1'b0}}, w_share};
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  always_comb begin
    s.in_ready  = (r_state == IDLE);
    s.out_valid = (r_state == EMIT);
    s.share_out = (r_state == EMIT) ? w_share : '0;
    s.share_idx = r_idx;
    s.out_last  = (r_state == EMIT) && w_last;
    s.err       = (r_state == ERR);
  end
endmodule

// File: tb/tb_sum4_splitter.sv
// Bench for sum4_splitter: vector table, hand-written corner sequences, random totals vs. a split model.
module tb_sum4_splitter;
  typedef struct {
    int t;
    int s[4];
    bit is_err;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sum4_splitter_if #(.W_IN(6), .W_OUT(4), .N_OUT(4)) bus ();
  sum4_splitter #(.W_IN(6), .W_OUT(4), .N_OUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Share i of total t, derived directly from the split rule.
  function automatic int model_share(input int t, input int i);
`ifdef SUM4_SPLIT_EVEN_EN
    return t / 4 + ((i < t % 4) ? 1 : 0);
`else
    int rem = t;
    int sh  = 0;
    for (int k = 0; k <= i; k++) begin
      sh  = (rem > 15) ? 15 : rem;
      rem = rem - sh;
    end
    return sh;
`endif
  endfunction

  function automatic vec_t mk(input int t, input int a, input int b, input int c, input int d, input bit e);
    vec_t v;
    v.t = t; v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d; v.is_err = e;
    return v;
  endfunction

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles at beat 1
  task automatic run_total(input int t, input int exp[4], input bit exp_err, input int mode);
    int beat = 0, cyc = 1, stalls = 0, sum = 0;
    bit held = 0, rdy;
    logic [31:0] p_share, p_idx, p_last;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.total_in = 6'(t);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (exp_err) begin
      check("err_pulse", bus.err, 1);
      check("err_no_valid", bus.out_valid, 0);
      check("err_busy", bus.in_ready, 0);
      @(negedge clk);
      check("err_one_cycle", bus.err, 0);
      check("err_no_valid2", bus.out_valid, 0);
      check("err_ready_back", bus.in_ready, 1);
      return;
    end
    while (beat < 4 && cyc < 64) begin
      check("emit_valid", bus.out_valid, 1);
      check("emit_busy", bus.in_ready, 0);
      if (held) begin
        check("hold_share", bus.share_out, p_share);
        check("hold_idx", bus.share_idx, p_idx);
        check("hold_last", bus.out_last, p_last);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 1) == 1);
        default: begin
          rdy = !(beat == 1 && stalls < 3);
          if (!rdy) stalls++;
        end
      endcase
      bus.out_ready = rdy;
      if (rdy) begin
        check("share", bus.share_out, exp[beat]);
        check("share_idx", bus.share_idx, beat);
        check("out_last", bus.out_last, (beat == 3) ? 1 : 0);
        sum += int'(bus.share_out);
        beat++;
        held = 0;
      end else begin
        held    = 1;
        p_share = bus.share_out;
        p_idx   = bus.share_idx;
        p_last  = bus.out_last;
      end
      @(negedge clk);
      cyc++;
    end
    check("beat_count", beat, 4);
    check("share_sum", sum, t);
    check("done_in_ready", bus.in_ready, 1);
    check("done_no_valid", bus.out_valid, 0);
    if (mode == 0) check("turnaround", cyc, 5);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs[$];
    int   e[4];
    int   t;

`ifdef SUM4_SPLIT_EVEN_EN
    vecs.push_back(mk(33, 9, 8, 8, 8, 0));
    vecs.push_back(mk(60, 15, 15, 15, 15, 0));
    vecs.push_back(mk(3, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(7, 2, 2, 2, 1, 0));
    vecs.push_back(mk(61, 0, 0, 0, 0, 1));
    vecs.push_back(mk(63, 0, 0, 0, 0, 1));
`else
    vecs.push_back(mk(33, 15, 15, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(60, 15, 15, 15, 15, 0));
    vecs.push_back(mk(61, 0, 0, 0, 0, 1));
    vecs.push_back(mk(15, 15, 0, 0, 0, 0));
    vecs.push_back(mk(16, 15, 1, 0, 0, 0));
    vecs.push_back(mk(45, 15, 15, 15, 0, 0));
    vecs.push_back(mk(63, 0, 0, 0, 0, 1));
`endif

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.total_in  = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_share", bus.share_out, 0);
    check("rst_idx", bus.share_idx, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_err", bus.err, 0);
    reset = 1'b0;

    foreach (vecs[i]) run_total(vecs[i].t, vecs[i].s, vecs[i].is_err, 0);

    // Backpressure at beat 1
    for (int i = 0; i < 4; i++) e[i] = model_share(20, i);
    run_total(20, e, 0, 2);

    // Reset during beat 2 aborts the split
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.total_in = 6'd45;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_idx", bus.share_idx, 2);
    check("pre_rst_share", bus.share_out, model_share(45, 2));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_idx", bus.share_idx, 0);
    check("abort_share", bus.share_out, 0);
    check("abort_last", bus.out_last, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) e[i] = model_share(7, i);
    run_total(7, e, 0, 0);

    for (int n = 0; n < 40; n++) begin
      t = $urandom_range(0, 63);
      for (int i = 0; i < 4; i++) e[i] = model_share(t, i);
      run_total(t, e, t > 60, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
